// File: rtl/vend_if.sv
// Coin/cancel inputs and sale outputs of the vending controller.
// master drives the buttons, slave is the controller.
interface vend_if #(
    parameter int N_COINS  = 3,
    parameter int CREDIT_W = 8
);
    logic [N_COINS-1:0]  i_coin;
    logic                i_cancel;
    logic [CREDIT_W-1:0] o_credit;
    logic                o_vend;
    logic [CREDIT_W-1:0] o_change;
    logic                o_change_valid;
    logic [N_COINS-1:0]  o_reject;
    logic                o_busy;

    modport master (
        output i_coin, i_cancel,
        input  o_credit, o_vend, o_change, o_change_valid, o_reject, o_busy
    );

    modport slave (
        input  i_coin, i_cancel,
        output o_credit, o_vend, o_change, o_change_valid, o_reject, o_busy
    );
endinterface

// File: rtl/vend_ctrl.sv
// Vending controller: per-channel sync/debounce/edge detect feeding
// a credit accumulator and a COLLECT/VEND/CHANGE sale FSM.
module vend_ctrl #(
    parameter int N_COINS     = 3,
    parameter int CREDIT_W    = 8,
    parameter logic [N_COINS*CREDIT_W-1:0] COIN_VALS =
        {8'd100, 8'd50, 8'd25},
    parameter int PRICE       = 150,
    parameter int DEB_CYCLES  = 50000,
    parameter int DISP_CYCLES = 50000000
) (
    input  logic i_clk,
    input  logic i_rst,
    vend_if.slave bus
);
    localparam int NCH = N_COINS + 1;
    localparam int CW  = $clog2(DEB_CYCLES + 1);
    localparam int DW  = $clog2(DISP_CYCLES + 1);

    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

    logic [NCH-1:0]     raw, s1, s2, deb, deb_q, ev;
    logic [CW-1:0]      cnt [NCH];
    logic [N_COINS-1:0] coin_ev, lowest;
    logic               cancel_ev;

    assign raw       = {bus.i_cancel, bus.i_coin};
    assign ev        = deb & ~deb_q;
    assign coin_ev   = ev[N_COINS-1:0];
    assign cancel_ev = ev[N_COINS];
    assign lowest    = coin_ev & (~coin_ev + N_COINS'(1));

    // Synchronise, debounce and remember last debounced level.
    // Levels reset high so a button held through reset is ignored.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            s1    <= '1;
            s2    <= '1;
            deb   <= '1;
            deb_q <= '1;
            for (int k = 0; k < NCH; k++) cnt[k] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;
            for (int k = 0; k < NCH; k++) begin
                if (s2[k] == deb[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CW'(DEB_CYCLES - 1)) begin
                    cnt[k] <= '0;
                    deb[k] <= ~deb[k];
                end else begin
                    cnt[k] <= cnt[k] + CW'(1);
                end
            end
        end
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic [DW-1:0]       vcnt_q, vcnt_d;
    logic [N_COINS-1:0]  reject_q, reject_d;
    logic [CREDIT_W-1:0] add, sum;
    logic                vend_q, valid_q, busy_q;

    // Next-state, credit and rejection decisions.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        vcnt_d   = vcnt_q;
        reject_d = coin_ev;
        add      = '0;
        for (int k = 0; k < N_COINS; k++) begin
            if (lowest[k]) add = COIN_VALS[k*CREDIT_W +: CREDIT_W];
        end
        sum = credit_q + add;
        unique case (state_q)
            COLLECT: begin
                if (cancel_ev && credit_q != '0) begin
                    change_d = credit_q;
                    state_d  = CHANGE;
                end else begin
                    reject_d = coin_ev & ~lowest;
                    credit_d = sum;
                    if (sum >= CREDIT_W'(PRICE)) begin
                        state_d = VEND;
                        vcnt_d  = DW'(DISP_CYCLES);
                    end
                end
            end
            VEND: begin
                if (vcnt_q == DW'(1)) begin
                    state_d  = CHANGE;
                    vcnt_d   = '0;
                    change_d = credit_q - CREDIT_W'(PRICE);
                end else begin
                    vcnt_d = vcnt_q - DW'(1);
                end
            end
            CHANGE: begin
                credit_d = '0;
                change_d = '0;
                state_d  = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= COLLECT;
            credit_q <= '0;
            change_q <= '0;
            vcnt_q   <= '0;
            reject_q <= '0;
            vend_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            vcnt_q   <= vcnt_d;
            reject_q <= reject_d;
            vend_q   <= (state_d == VEND);
            valid_q  <= (state_d == CHANGE);
            busy_q   <= (state_d != COLLECT);
        end
    end

    assign bus.o_credit       = credit_q;
    assign bus.o_change       = change_q;
    assign bus.o_reject       = reject_q;
    assign bus.o_vend         = vend_q;
    assign bus.o_change_valid = valid_q;
    assign bus.o_busy         = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: table of button presses with expected credit,
// dispense, change and reject results, plus bounce and reset cases.
module tb_vend_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    vend_if #(.N_COINS(3), .CREDIT_W(8)) bus ();

    vend_ctrl #(
        .DEB_CYCLES (4),
        .DISP_CYCLES(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0] coin;
        logic       cancel;
        int         peak;
        int         fin;
        int         vend;
        int         chg;
        int         change;
        logic [2:0] rej;
    } vec_t;

    vec_t vecs [13];
    int checks = 0;
    int errors = 0;

    int vend_tot = 0;
    int chg_tot  = 0;
    int last_chg = 0;
    int seq_bad  = 0;
    int rej_tot [3] = '{0, 0, 0};
    logic prev_vend = 1'b0;

    // Cumulative observation of the outputs, just after each edge.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            prev_vend = 1'b0;
        end else begin
            vend_tot += int'(bus.o_vend);
            chg_tot  += int'(bus.o_change_valid);
            if (bus.o_change_valid) last_chg = int'(bus.o_change);
            for (int b = 0; b < 3; b++) rej_tot[b] += int'(bus.o_reject[b]);
            if (prev_vend && !bus.o_vend && !bus.o_change_valid) seq_bad++;
            if (bus.o_vend && bus.o_credit < 8'd150) seq_bad++;
            if (!bus.o_vend && !bus.o_change_valid && bus.o_credit >= 8'd150)
                seq_bad++;
            prev_vend = bus.o_vend;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] m, input logic c,
                         output int peak, output int fin);
        peak = 0;
        bus.i_coin   = m;
        bus.i_cancel = c;
        repeat (12) begin
            @(negedge clk);
            if (int'(bus.o_credit) > peak) peak = int'(bus.o_credit);
        end
        bus.i_coin   = '0;
        bus.i_cancel = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (int'(bus.o_credit) > peak) peak = int'(bus.o_credit);
        end
        fin = int'(bus.o_credit);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_credit"}, int'(bus.o_credit), 0);
        chk({tag, "_vend"}, int'(bus.o_vend), 0);
        chk({tag, "_change"}, int'(bus.o_change), 0);
        chk({tag, "_valid"}, int'(bus.o_change_valid), 0);
        chk({tag, "_reject"}, int'(bus.o_reject), 0);
        chk({tag, "_busy"}, int'(bus.o_busy), 0);
    endtask

    initial begin
        int peak, fin, v0, c0, n;
        int r0 [3];

        vecs[0]  = '{3'b001, 1'b0,  25,  25, 0, 0,  0, 3'b000};
        vecs[1]  = '{3'b001, 1'b0,  50,  50, 0, 0,  0, 3'b000};
        vecs[2]  = '{3'b001, 1'b0,  75,  75, 0, 0,  0, 3'b000};
        vecs[3]  = '{3'b001, 1'b0, 100, 100, 0, 0,  0, 3'b000};
        vecs[4]  = '{3'b001, 1'b0, 125, 125, 0, 0,  0, 3'b000};
        vecs[5]  = '{3'b001, 1'b0, 150,   0, 8, 1,  0, 3'b000};
        vecs[6]  = '{3'b100, 1'b0, 100, 100, 0, 0,  0, 3'b000};
        vecs[7]  = '{3'b100, 1'b0, 200,   0, 8, 1, 50, 3'b000};
        vecs[8]  = '{3'b010, 1'b0,  50,  50, 0, 0,  0, 3'b000};
        vecs[9]  = '{3'b000, 1'b1,  50,   0, 0, 1, 50, 3'b000};
        vecs[10] = '{3'b101, 1'b0,  25,  25, 0, 0,  0, 3'b100};
        vecs[11] = '{3'b100, 1'b0, 125, 125, 0, 0,  0, 3'b000};
        vecs[12] = '{3'b010, 1'b0, 175,   0, 8, 1, 25, 3'b000};

        bus.i_coin   = '0;
        bus.i_cancel = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk_zero("idle");

        for (int i = 0; i < 13; i++) begin
            v0 = vend_tot;
            c0 = chg_tot;
            for (int b = 0; b < 3; b++) r0[b] = rej_tot[b];
            press(vecs[i].coin, vecs[i].cancel, peak, fin);
            chk($sformatf("v%0d_peak", i), peak, vecs[i].peak);
            chk($sformatf("v%0d_fin", i), fin, vecs[i].fin);
            chk($sformatf("v%0d_vend", i), vend_tot - v0, vecs[i].vend);
            chk($sformatf("v%0d_chg", i), chg_tot - c0, vecs[i].chg);
            if (vecs[i].chg > 0)
                chk($sformatf("v%0d_change", i), last_chg, vecs[i].change);
            for (int b = 0; b < 3; b++)
                chk($sformatf("v%0d_rej%0d", i, b), rej_tot[b] - r0[b],
                    int'(vecs[i].rej[b]));
        end

        // ch1 pressed while a ch2 coin is dispensing
        press(3'b100, 1'b0, peak, fin);
        chk("pre_credit", fin, 100);
        v0 = vend_tot;
        c0 = chg_tot;
        r0[1] = rej_tot[1];
        bus.i_coin = 3'b100;
        repeat (2) @(negedge clk);
        peak = 0;
        bus.i_coin = 3'b110;
        repeat (12) begin
            @(negedge clk);
            if (int'(bus.o_credit) > peak) peak = int'(bus.o_credit);
        end
        bus.i_coin = '0;
        repeat (16) begin
            @(negedge clk);
            if (int'(bus.o_credit) > peak) peak = int'(bus.o_credit);
        end
        chk("vrej_peak", peak, 200);
        chk("vrej_rej1", rej_tot[1] - r0[1], 1);
        chk("vrej_vend", vend_tot - v0, 8);
        chk("vrej_chg", chg_tot - c0, 1);
        chk("vrej_change", last_chg, 50);
        chk("vrej_fin", int'(bus.o_credit), 0);

        // ch1 bounce then clean hold
        for (int t = 0; t < 10; t++) begin
            bus.i_coin[1] = ~bus.i_coin[1];
            repeat (2) @(negedge clk);
        end
        press(3'b010, 1'b0, peak, fin);
        chk("bounce_peak", peak, 50);
        chk("bounce_fin", fin, 50);

        // reset mid-VEND with ch0 held
        bus.i_coin = 3'b100;
        repeat (2) @(negedge clk);
        bus.i_coin = 3'b101;
        n = 0;
        while (!bus.o_vend && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rs_vend_start", int'(bus.o_vend), 1);
        repeat (3) @(negedge clk);
        c0 = chg_tot;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b1;
        bus.i_coin = 3'b001;
        v0 = vend_tot;
        repeat (20) @(negedge clk);
        chk("rs_held_credit", int'(bus.o_credit), 0);
        chk("rs_no_change", chg_tot - c0, 0);
        chk("rs_no_vend", vend_tot - v0, 0);
        bus.i_coin = '0;
        repeat (12) @(negedge clk);
        press(3'b001, 1'b0, peak, fin);
        chk("rs_repress", fin, 25);

        chk("sequence", seq_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
